// File: rtl/qpsk_pkg.sv
// Shared types, phase constants and defaults for the QPSK symbol scheduler.
package qpsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int DEF_SAMPLES_PER_CYC = 100;

    localparam logic [6:0] PH_00 = 7'd0;
    localparam logic [6:0] PH_01 = 7'd25;
    localparam logic [6:0] PH_10 = 7'd50;
    localparam logic [6:0] PH_11 = 7'd75;

    // Quarter-period offsets into the modulator's sine table, one per {O,E}.
    function automatic logic [6:0] dibit_phase(input logic [1:0] dibit);
        case (dibit)
            2'b00:   return PH_00;
            2'b01:   return PH_01;
            2'b10:   return PH_10;
            default: return PH_11;
        endcase
    endfunction

endpackage

// File: rtl/qpsk_sym_timer.sv
// Sample/carrier-cycle counters; sym_tick marks the last sample of a symbol.
module qpsk_sym_timer
    import qpsk_pkg::*;
#(
    parameter int SAMPLES_PER_CYC = DEF_SAMPLES_PER_CYC,
    parameter int CYC_PER_SYM     = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clear,
    output logic sym_tick
);

    localparam int SW = (SAMPLES_PER_CYC > 1) ? $clog2(SAMPLES_PER_CYC) : 1;
    localparam int CW = (CYC_PER_SYM > 1) ? $clog2(CYC_PER_SYM) : 1;
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_CYC - 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(CYC_PER_SYM - 1);

    logic [SW-1:0] samp_cnt;
    logic [CW-1:0] cyc_cnt;
    logic          samp_wrap;
    logic          cyc_wrap;

    assign samp_wrap = (samp_cnt == SAMP_LAST);
    assign cyc_wrap  = (cyc_cnt == CYC_LAST);
    assign sym_tick  = samp_wrap && cyc_wrap;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            samp_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (clear) begin
            samp_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (samp_wrap) begin
            samp_cnt <= '0;
            cyc_cnt  <= cyc_wrap ? '0 : cyc_cnt + 1'b1;
        end else begin
            samp_cnt <= samp_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qpsk_symbol_scheduler.sv
// Byte-to-dibit scheduler feeding the QPSK sine-LUT modulator.
// Define QPSK_PREAMBLE_EN to prepend an alternating 00/11 preamble to every burst.
module qpsk_symbol_scheduler
    import qpsk_pkg::*;
#(
    parameter int SAMPLES_PER_CYC = DEF_SAMPLES_PER_CYC,
    parameter int CYC_PER_SYM     = 4,
    parameter int DATA_W          = 8,
    parameter int PREAMBLE_LEN    = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              O,
    output logic              E,
    output logic              sym_strobe,
    output logic [6:0]        phase_idx,
    output logic              busy,
    output logic              underrun
);

    localparam int NDIB = DATA_W / 2;
    localparam int LW   = $clog2(NDIB + 1);
    localparam int PW   = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam logic [LW-1:0] LEFT_FULL = LW'(NDIB);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_LEN - 1);

    state_t            state_q, state_d;
    logic              launch_q, launch_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [LW-1:0]     left_q, left_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              stop_q, stop_d;
    logic [PW-1:0]     pre_cnt_q, pre_cnt_d;
    logic [1:0]        dibit_q, dibit_d;
    logic [6:0]        phase_q;
    logic              strobe_q, strobe_d;
    logic              underrun_q, underrun_d;
    logic              busy_q, busy_d;
    logic              alive_q;

    logic              handshake;
    logic              sym_tick;
    logic              timer_clear;
    logic [DATA_W-1:0] next_word;

    assign s_ready     = alive_q && en && !stop_q && !pend_vld_q;
    assign handshake   = s_valid && s_ready;
    assign timer_clear = (state_q == ST_IDLE) || launch_q;
    // A byte arriving on the tick that drains the shift register bypasses pending.
    assign next_word   = pend_vld_q ? pend_q : s_data;

    qpsk_sym_timer #(
        .SAMPLES_PER_CYC(SAMPLES_PER_CYC),
        .CYC_PER_SYM    (CYC_PER_SYM)
    ) u_timer (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .clear   (timer_clear),
        .sym_tick(sym_tick)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        launch_d   = 1'b0;
        shift_d    = shift_q;
        left_d     = left_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        stop_d     = stop_q;
        pre_cnt_d  = pre_cnt_q;
        dibit_d    = dibit_q;
        strobe_d   = 1'b0;
        underrun_d = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (handshake) begin
                    shift_d   = s_data;
                    left_d    = LEFT_FULL;
                    launch_d  = 1'b1;
                    pre_cnt_d = '0;
`ifdef QPSK_PREAMBLE_EN
                    state_d   = ST_PRE;
`else
                    state_d   = ST_RUN;
`endif
                end
            end
            default: begin
                if (!en) stop_d = 1'b1;
                if (handshake) begin
                    pend_d     = s_data;
                    pend_vld_d = 1'b1;
                end

                if (launch_q) begin
                    busy_d   = 1'b1;
                    strobe_d = 1'b1;
                    if (state_q == ST_PRE) begin
                        dibit_d = 2'b00;
                    end else begin
                        dibit_d = shift_q[DATA_W-1 -: 2];
                        shift_d = shift_q << 2;
                        left_d  = left_q - 1'b1;
                    end
                end else if (sym_tick) begin
                    if (stop_q || !en) begin
                        state_d    = ST_IDLE;
                        dibit_d    = 2'b00;
                        busy_d     = 1'b0;
                        left_d     = '0;
                        pend_vld_d = 1'b0;
                        stop_d     = 1'b0;
                    end else if (state_q == ST_PRE) begin
                        strobe_d = 1'b1;
                        if (pre_cnt_q == PRE_LAST) begin
                            state_d = ST_RUN;
                            dibit_d = shift_q[DATA_W-1 -: 2];
                            shift_d = shift_q << 2;
                            left_d  = left_q - 1'b1;
                        end else begin
                            pre_cnt_d = pre_cnt_q + 1'b1;
                            dibit_d   = {2{~pre_cnt_q[0]}};
                        end
                    end else if (left_q != '0) begin
                        strobe_d = 1'b1;
                        dibit_d  = shift_q[DATA_W-1 -: 2];
                        shift_d  = shift_q << 2;
                        left_d   = left_q - 1'b1;
                    end else if (pend_vld_q || handshake) begin
                        strobe_d   = 1'b1;
                        dibit_d    = next_word[DATA_W-1 -: 2];
                        shift_d    = next_word << 2;
                        left_d     = LEFT_FULL - 1'b1;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d    = ST_IDLE;
                        dibit_d    = 2'b00;
                        busy_d     = 1'b0;
                        underrun_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            launch_q   <= 1'b0;
            shift_q    <= '0;
            left_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            stop_q     <= 1'b0;
            pre_cnt_q  <= '0;
            dibit_q    <= 2'b00;
            phase_q    <= PH_00;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
            alive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            launch_q   <= launch_d;
            shift_q    <= shift_d;
            left_q     <= left_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            stop_q     <= stop_d;
            pre_cnt_q  <= pre_cnt_d;
            dibit_q    <= dibit_d;
            phase_q    <= dibit_phase(dibit_d);
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
            alive_q    <= 1'b1;
        end
    end

    assign O          = dibit_q[1];
    assign E          = dibit_q[0];
    assign phase_idx  = phase_q;
    assign sym_strobe = strobe_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

endmodule
